// File: rtl/integrator_pkg.sv
// Shared PID definitions: default path widths, integrator FSM encoding, saturating clamp.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: not applicable.
package integrator_pkg;

   localparam int PID_E_W       = 8;
   localparam int PID_K_W       = 8;
   localparam int PID_SHIFT     = 4;
   localparam int PID_ACC_W     = 16;
   localparam int PID_OUT_SHIFT = 4;
   localparam int PID_OUT_W     = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      ACC  = 2'd2,
      OUT  = 2'd3
   } state_t;

   // Clamp a signed value to the signed range of a w-bit word (w <= 31).
   // The caller truncates the result to w bits; comparing the result with
   // the input tells whether the clamp was applied.
   function automatic logic signed [31:0] sat_clamp(input logic signed [31:0] x, input int w);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (w - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (w - 1));
      if (x > hi) begin
         return hi;
      end else if (x < lo) begin
         return lo;
      end
      return x;
   endfunction

endpackage

// File: rtl/integrator_if.sv
// Sample-in / contribution-out bundle of the integral path.
// Latency: none (wires only).
// Backpressure: none; samples offered while the block is busy are dropped and flagged.
interface integrator_if #(
   parameter int E_W   = 8,
   parameter int K_W   = 8,
   parameter int OUT_W = 8
);
   logic                    e_valid;
   logic signed [E_W-1:0]   e;
   logic        [K_W-1:0]   K_i;
   logic signed [OUT_W-1:0] i_contrib;
   logic                    i_valid;
   logic                    busy;
   logic                    sat;
   logic                    overrun;

   modport master (
      output e_valid, e, K_i,
      input  i_contrib, i_valid, busy, sat, overrun
   );

   modport slave (
      input  e_valid, e, K_i,
      output i_contrib, i_valid, busy, sat, overrun
   );
endinterface

// File: rtl/integrator_shift_add_mult.sv
// Sequential signed x unsigned shift-add multiplier, one multiplier bit per cycle, LSB first.
// Latency: B_W enabled cycles after start; done is high during the cycle that adds the last bit.
// Backpressure: ena low freezes it; abort drops an in-flight product; start is only honoured from the caller's idle state.
module shift_add_mult #(
   parameter int A_W = 8,
   parameter int B_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ena,
   input  logic                     abort,
   input  logic                     start,
   input  logic signed [A_W-1:0]    a,
   input  logic        [B_W-1:0]    b,
   output logic signed [A_W+B_W-1:0] prod,
   output logic                     done
);
   localparam int P_W   = A_W + B_W;
   localparam int CNT_W = (B_W > 1) ? $clog2(B_W) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(B_W - 1);

   logic signed [A_W-1:0] a_q;
   logic        [B_W-1:0] b_q;
   logic        [CNT_W-1:0] cnt;
   logic                  running;
   logic signed [P_W-1:0] addend;

   // Partial product for the current bit: sign-extended multiplicand shifted to the bit position.
   assign addend = P_W'(a_q) << cnt;
   assign done   = running && (cnt == LAST);

   // Operand latch on start, then one conditional add per enabled cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         cnt     <= '0;
         running <= 1'b0;
         prod    <= '0;
      end else if (abort) begin
         cnt     <= '0;
         running <= 1'b0;
      end else if (ena) begin
         if (start) begin
            a_q     <= a;
            b_q     <= b;
            cnt     <= '0;
            running <= 1'b1;
            prod    <= '0;
         end else if (running) begin
            if (b_q[cnt]) begin
               prod <= prod + addend;
            end
            if (cnt == LAST) begin
               running <= 1'b0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end
endmodule

// File: rtl/integrator.sv
// PID integral path: scale error by K_i, accumulate with anti-windup clamp, register saturated contribution.
// Latency: K_W+2 enabled cycles from accepted e_valid to i_valid; one sample per K_W+3 cycles at best.
// Backpressure: none; e_valid while busy is dropped and sets sticky overrun, ena low freezes everything.
module integrator import integrator_pkg::*; #(
   parameter int E_W       = PID_E_W,
   parameter int K_W       = PID_K_W,
   parameter int SHIFT     = PID_SHIFT,
   parameter int ACC_W     = PID_ACC_W,
   parameter int OUT_SHIFT = PID_OUT_SHIFT,
   parameter int OUT_W     = PID_OUT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ena,
   input  logic         clear,
   integrator_if.slave  bus
);
   localparam int P_W   = E_W + K_W;
   localparam int SUM_W = ACC_W + 1;

   state_t                  state_q, state_d;
   logic                    mult_start;
   logic                    mult_done;
   logic signed [P_W-1:0]   prod;
   logic signed [P_W-1:0]   term;
   logic signed [SUM_W-1:0] sum;
   logic signed [ACC_W-1:0] acc;
   logic signed [OUT_W-1:0] i_contrib_q;
   logic                    i_valid_q;
   logic                    sat_q;
   logic                    overrun_q;

   shift_add_mult #(.A_W(E_W), .B_W(K_W)) u_mult (
      .clk   (clk),
      .rst   (rst),
      .ena   (ena),
      .abort (clear),
      .start (mult_start),
      .a     (bus.e),
      .b     (bus.K_i),
      .prod  (prod),
      .done  (mult_done)
   );

   // Drop the fractional gain bits (floor), then add with one guard bit so the clamp sees the true sum.
   assign term = prod >>> SHIFT;
   assign sum  = SUM_W'(acc) + SUM_W'(term);

   // State register; clear aborts from any state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else if (clear) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and multiplier kick-off; nothing advances while ena is low.
   always_comb begin
      state_d    = state_q;
      mult_start = 1'b0;
      if (ena) begin
         case (state_q)
            IDLE: begin
               if (bus.e_valid) begin
                  mult_start = 1'b1;
                  state_d    = MUL;
               end
            end
            MUL:     if (mult_done) state_d = ACC;
            ACC:     state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Accumulator, output register and status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc         <= '0;
         i_contrib_q <= '0;
         i_valid_q   <= 1'b0;
         sat_q       <= 1'b0;
         overrun_q   <= 1'b0;
      end else if (clear) begin
         acc         <= '0;
         i_contrib_q <= '0;
         i_valid_q   <= 1'b0;
         sat_q       <= 1'b0;
         overrun_q   <= 1'b0;
      end else if (ena) begin
         i_valid_q <= 1'b0;
         if (state_q != IDLE && bus.e_valid) begin
            overrun_q <= 1'b1;
         end
         case (state_q)
            ACC: begin
               acc   <= ACC_W'(sat_clamp(32'(sum), ACC_W));
               sat_q <= (sat_clamp(32'(sum), ACC_W) != 32'(sum));
            end
            OUT: begin
               i_contrib_q <= OUT_W'(sat_clamp(32'(acc >>> OUT_SHIFT), OUT_W));
               i_valid_q   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.i_contrib = i_contrib_q;
   assign bus.i_valid   = i_valid_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.sat       = sat_q;
   assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_integrator.sv
// Directed bench for the integral path with a queue scoreboard of expected contributions.
// Latency: each expected entry carries the cycle its i_valid must appear in.
// Backpressure: samples offered while busy are driven without a scoreboard entry.
module tb_integrator;
   logic clk = 1'b0;
   logic rst;
   logic ena;
   logic clear;

   always #5 clk = ~clk;

   integrator_if #(.E_W(8), .K_W(8), .OUT_W(8)) bus ();

   integrator #(
      .E_W(8), .K_W(8), .SHIFT(4), .ACC_W(16), .OUT_SHIFT(4), .OUT_W(8)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .ena   (ena),
      .clear (clear),
      .bus   (bus)
   );

   typedef struct {
      int contrib;
      bit sat;
      int at;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   acc_m    = 0;

   // Edge counter used to time i_valid against the accepting edge.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic int clampi(input int x, input int lo, input int hi);
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One-cycle e_valid pulse, no scoreboard entry (for dropped/aborted samples).
   task automatic pulse(input int ev, input int kv);
      bus.e_valid = 1'b1;
      bus.e       = ev[7:0];
      bus.K_i     = kv[7:0];
      @(negedge clk);
      bus.e_valid = 1'b0;
   endtask

   // Accepted sample: update the reference accumulator and queue the expected output.
   task automatic send(input int ev, input int kv, input int extra);
      exp_t x;
      int   s;
      s         = acc_m + ((ev * kv) >>> 4);
      x.sat     = (s > 32767) || (s < -32768);
      acc_m     = clampi(s, -32768, 32767);
      x.contrib = clampi(acc_m >>> 4, -128, 127);
      x.at      = cyc + 1 + 10 + extra;
      sb.push_back(x);
      pulse(ev, kv);
   endtask

   // Scoreboard consumer: every i_valid must match the oldest expected entry.
   always @(negedge clk) begin : monitor
      exp_t x;
      if (!rst && bus.i_valid) begin
         if (sb.size() == 0) begin
            chk("spurious_i_valid", 1, 0);
         end else begin
            x = sb.pop_front();
            chk("i_contrib", $signed(bus.i_contrib), x.contrib);
            chk("sat", bus.sat, x.sat);
            chk("i_valid_cycle", cyc, x.at);
         end
      end
   end

   initial begin
      rst         = 1'b1;
      ena         = 1'b1;
      clear       = 1'b0;
      bus.e_valid = 1'b0;
      bus.e       = '0;
      bus.K_i     = '0;
      wait_cycles(3);
      chk("rst_i_contrib", $signed(bus.i_contrib), 0);
      chk("rst_i_valid", bus.i_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_sat", bus.sat, 0);
      chk("rst_overrun", bus.overrun, 0);
      rst = 1'b0;
      wait_cycles(1);

      // Reset held for three cycles in the middle of a multiply.
      pulse(16, 16);
      wait_cycles(3);
      chk("busy_mid_mul", bus.busy, 1);
      rst = 1'b1;
      wait_cycles(3);
      chk("rst_mid_busy", bus.busy, 0);
      chk("rst_mid_i_contrib", $signed(bus.i_contrib), 0);
      chk("rst_mid_acc", $signed(dut.acc), 0);
      rst = 1'b0;
      wait_cycles(13);

      // Basic accumulation at maximum throughput.
      for (int i = 0; i < 4; i++) begin
         send(16, 16, 0);
         wait_cycles(10);
      end
      chk("basic_final_contrib", $signed(bus.i_contrib), 4);
      chk("basic_sat", bus.sat, 0);

      // Negative samples wind back down, then floor rounding of a tiny term.
      for (int i = 0; i < 4; i++) begin
         send(-16, 16, 0);
         wait_cycles(10);
      end
      chk("neg_final_contrib", $signed(bus.i_contrib), 0);
      send(-1, 1, 0);
      wait_cycles(10);
      chk("floor_acc", $signed(dut.acc), -1);
      chk("floor_contrib", $signed(bus.i_contrib), -1);

      // Saturation / anti-windup.
      clear = 1'b1;
      wait_cycles(1);
      clear = 1'b0;
      acc_m = 0;
      chk("clear_acc", $signed(dut.acc), 0);
      for (int i = 0; i < 16; i++) begin
         send(127, 255, 0);
         wait_cycles(10);
      end
      chk("sat16_acc", $signed(dut.acc), 32384);
      chk("sat16_flag", bus.sat, 0);
      send(127, 255, 0);
      wait_cycles(10);
      chk("sat17_acc", $signed(dut.acc), 32767);
      chk("sat17_flag", bus.sat, 1);
      chk("sat17_contrib", $signed(bus.i_contrib), 127);
      send(-128, 255, 0);
      wait_cycles(10);
      chk("unwind_acc", $signed(dut.acc), 30727);
      chk("unwind_sat", bus.sat, 0);

      // Overrun: second sample three edges after the first is dropped.
      clear = 1'b1;
      wait_cycles(1);
      clear = 1'b0;
      acc_m = 0;
      send(16, 16, 0);
      wait_cycles(2);
      pulse(5, 5);
      wait_cycles(12);
      chk("overrun_set", bus.overrun, 1);
      chk("overrun_acc", $signed(dut.acc), 16);

      // Clear in the middle of a multiply discards the sample.
      pulse(16, 16);
      wait_cycles(4);
      clear = 1'b1;
      wait_cycles(1);
      clear = 1'b0;
      acc_m = 0;
      chk("clear_mid_acc", $signed(dut.acc), 0);
      chk("clear_mid_overrun", bus.overrun, 0);
      chk("clear_mid_busy", bus.busy, 0);
      chk("clear_mid_contrib", $signed(bus.i_contrib), 0);
      wait_cycles(14);

      // Enable freeze: five low cycles during MUL, with an ignored e_valid.
      send(16, 16, 5);
      wait_cycles(2);
      ena = 1'b0;
      wait_cycles(1);
      pulse(7, 7);
      wait_cycles(3);
      ena = 1'b1;
      wait_cycles(10);
      chk("freeze_overrun", bus.overrun, 0);
      chk("freeze_contrib", $signed(bus.i_contrib), 1);

      for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
